// File: rtl/readout_frame_packer.sv
// Packs pixel samples into WIDTH_OUTPUT-bit words and hands one word per serializer frame.
// Words are handed over only on the slot WIDTH_OUTPUT-1 -> 0 edge; a missed boundary raises sticky underrun.
module readout_frame_packer #(
  parameter int WIDTH_OUTPUT = 128,
  parameter int PIX_WIDTH    = 8,
  localparam int PIX_PER_WORD = WIDTH_OUTPUT / PIX_WIDTH,
  localparam int SLOT_W       = $clog2(WIDTH_OUTPUT),
  localparam int IDX_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [PIX_WIDTH-1:0]    pix_data,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic                    clear_flags,
  output logic [WIDTH_OUTPUT-1:0] frame_word,
  output logic                    frame_load,
  output logic                    underrun,
  output logic [SLOT_W-1:0]       slot_count
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WIDTH_OUTPUT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PIX_PER_WORD - 1);

  state_e                  state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [IDX_W-1:0]        pix_idx_q, pix_idx_d;
  logic [WIDTH_OUTPUT-1:0] frame_word_q, frame_word_d;
  logic                    frame_load_q, frame_load_d;
  logic                    underrun_q, underrun_d;
  logic                    underrun_set;
  logic                    boundary;
  logic                    accept;
  logic [WIDTH_OUTPUT-1:0] staging;

  assign boundary = (slot_q == LAST_SLOT);
  assign accept   = pix_valid && (state_q == FILL);

  // One register per pixel lane; lane k holds the k-th pixel of the word being filled.
  for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
    logic [PIX_WIDTH-1:0] lane_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        lane_q <= '0;
      end else if (accept && (pix_idx_q == IDX_W'(gi))) begin
        lane_q <= pix_data;
      end
    end

    assign staging[gi*PIX_WIDTH +: PIX_WIDTH] = lane_q;
  end

  always_comb begin
    slot_d       = boundary ? '0 : slot_q + SLOT_W'(1);
    state_d      = state_q;
    pix_idx_d    = pix_idx_q;
    frame_word_d = frame_word_q;
    frame_load_d = 1'b0;
    underrun_set = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (pix_idx_q == LAST_IDX) begin
            pix_idx_d = '0;
            state_d   = FULL;
          end else begin
            pix_idx_d = pix_idx_q + IDX_W'(1);
          end
        end
        // Decision uses the pre-edge state, so a word completed on the boundary edge itself still underruns.
        if (boundary) begin
          underrun_set = 1'b1;
        end
      end
      FULL: begin
        if (boundary) begin
          frame_word_d = staging;
          frame_load_d = 1'b1;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    underrun_d = underrun_set ? 1'b1 : (clear_flags ? 1'b0 : underrun_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= FILL;
      slot_q       <= '0;
      pix_idx_q    <= '0;
      frame_word_q <= '0;
      frame_load_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      pix_idx_q    <= pix_idx_d;
      frame_word_q <= frame_word_d;
      frame_load_q <= frame_load_d;
      underrun_q   <= underrun_d;
    end
  end

  assign pix_ready  = (state_q == FILL);
  assign frame_word = frame_word_q;
  assign frame_load = frame_load_q;
  assign underrun   = underrun_q;
  assign slot_count = slot_q;

endmodule

// File: tb/tb_readout_frame_packer.sv
// Directed bench for readout_frame_packer: vector table for the fill phase plus hand-written frame sequences.
module tb_readout_frame_packer;

  logic         CLK;
  logic         RST_N;
  logic [7:0]   pix_data;
  logic         pix_valid;
  logic         pix_ready;
  logic         clear_flags;
  logic [127:0] frame_word;
  logic         frame_load;
  logic         underrun;
  logic [6:0]   slot_count;

  int vectors;
  int miscompares;
  int edges;

  readout_frame_packer #(.WIDTH_OUTPUT(128), .PIX_WIDTH(8)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .clear_flags (clear_flags),
    .frame_word  (frame_word),
    .frame_load  (frame_load),
    .underrun    (underrun),
    .slot_count  (slot_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       exp_ready;
    logic [6:0] exp_slot;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edges);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    edges++;
  endtask

  task automatic tick_to(input int n);
    while (edges < n) tick();
  endtask

  task automatic do_reset();
    pix_valid   = 1'b0;
    pix_data    = 8'h00;
    clear_flags = 1'b0;
    RST_N       = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_slot", 128'(slot_count), 128'd0);
    chk("rst_word", frame_word, 128'd0);
    chk("rst_load", 128'(frame_load), 128'd0);
    chk("rst_underrun", 128'(underrun), 128'd0);
    RST_N = 1'b1;
    edges = 0;
    chk("rst_ready", 128'(pix_ready), 128'd1);
  endtask

  function automatic logic [127:0] make_word(input logic [7:0] base);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[k*8 +: 8] = base + 8'(k);
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] word_a5;
    int acc, loads, bit_err, slot_err;
    vectors     = 0;
    miscompares = 0;
    edges       = 0;
    word_a5     = {16{8'hA5}};

    for (int k = 0; k < 16; k++) tbl[k] = '{1'b1, 8'(k), 1'b1, 7'(k)};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 7'd16};

    // Full-rate fill of 0x00..0x0F
    do_reset();
    for (int k = 0; k < 17; k++) begin
      pix_valid = tbl[k].valid;
      pix_data  = tbl[k].data;
      chk($sformatf("tbl%0d_ready", k), 128'(pix_ready), 128'(tbl[k].exp_ready));
      chk($sformatf("tbl%0d_slot", k), 128'(slot_count), 128'(tbl[k].exp_slot));
      tick();
    end
    pix_valid = 1'b0;
    tick_to(127);
    chk("s1_word_premature", frame_word, 128'd0);
    tick();
    chk("s1_word", frame_word, make_word(8'h00));
    chk("s1_load", 128'(frame_load), 128'd1);
    chk("s1_underrun", 128'(underrun), 128'd0);
    chk("s1_slot_wrap", 128'(slot_count), 128'd0);
    chk("s1_ready", 128'(pix_ready), 128'd1);
    tick();
    chk("s1_load_pulse", 128'(frame_load), 128'd0);

    // Pixels held off until slot 127; partial word must survive the underrun
    do_reset();
    tick_to(127);
    pix_valid = 1'b1;
    pix_data  = 8'h50;
    tick();
    pix_valid = 1'b0;
    chk("s2_underrun", 128'(underrun), 128'd1);
    chk("s2_word", frame_word, 128'd0);
    chk("s2_load", 128'(frame_load), 128'd0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("s2_clear", 128'(underrun), 128'd0);
    for (int k = 1; k < 16; k++) begin
      pix_valid = 1'b1;
      pix_data  = 8'h50 + 8'(k);
      tick();
    end
    pix_valid = 1'b0;
    chk("s2_full_ready", 128'(pix_ready), 128'd0);
    tick_to(255);
    chk("s2_word_hold", frame_word, 128'd0);
    tick();
    chk("s2_word", frame_word, make_word(8'h50));
    chk("s2_load2", 128'(frame_load), 128'd1);

    // 16th pixel accepted on the boundary edge itself
    do_reset();
    tick_to(112);
    for (int k = 0; k < 16; k++) begin
      pix_valid = 1'b1;
      pix_data  = 8'h10 + 8'(k);
      tick();
    end
    pix_valid = 1'b0;
    chk("s3_underrun", 128'(underrun), 128'd1);
    chk("s3_ready", 128'(pix_ready), 128'd0);
    chk("s3_word", frame_word, 128'd0);
    chk("s3_load", 128'(frame_load), 128'd0);
    tick_to(255);
    chk("s3_word_hold", frame_word, 128'd0);
    tick();
    chk("s3_word256", frame_word, make_word(8'h10));
    chk("s3_load256", 128'(frame_load), 128'd1);
    chk("s3_ready256", 128'(pix_ready), 128'd1);

    // Continuous 0xA5 stream for four frames with a serializer bit check per slot
    do_reset();
    pix_valid = 1'b1;
    pix_data  = 8'hA5;
    acc = 0; loads = 0; bit_err = 0; slot_err = 0;
    for (int e = 1; e <= 512; e++) begin
      if (pix_valid && pix_ready) acc++;
      tick();
      if (frame_load) loads++;
      if (slot_count != 7'(edges % 128)) slot_err++;
      if (edges >= 128 && frame_word[slot_count] !== word_a5[edges % 128]) bit_err++;
      if (edges % 128 == 0) begin
        chk($sformatf("s4_accepts_f%0d", edges / 128), 128'(acc), 128'd16);
        chk($sformatf("s4_loads_f%0d", edges / 128), 128'(loads), 128'd1);
        acc = 0;
        loads = 0;
      end
    end
    pix_valid = 1'b0;
    chk("s4_serial_bits", 128'(bit_err), 128'd0);
    chk("s4_slot_track", 128'(slot_err), 128'd0);
    chk("s4_underrun", 128'(underrun), 128'd0);
    chk("s4_word", frame_word, word_a5);

    // Reset at slot 60 with 10 pixels staged
    tick_to(562);
    for (int k = 0; k < 10; k++) begin
      pix_valid = 1'b1;
      pix_data  = 8'h30 + 8'(k);
      tick();
    end
    pix_valid = 1'b0;
    chk("s5_slot60", 128'(slot_count), 128'd60);
    #2;
    RST_N = 1'b0;
    #1;
    chk("s5_async_slot", 128'(slot_count), 128'd0);
    chk("s5_async_word", frame_word, 128'd0);
    chk("s5_async_load", 128'(frame_load), 128'd0);
    chk("s5_async_underrun", 128'(underrun), 128'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    edges = 0;
    chk("s5_ready", 128'(pix_ready), 128'd1);
    for (int k = 0; k < 16; k++) begin
      pix_valid = 1'b1;
      pix_data  = 8'h40 + 8'(k);
      tick();
    end
    pix_valid = 1'b0;
    tick_to(127);
    chk("s5_word_premature", frame_word, 128'd0);
    tick();
    chk("s5_word", frame_word, make_word(8'h40));

    // clear_flags on the same edge as a fresh underrun
    tick_to(255);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("s6_set_wins", 128'(underrun), 128'd1);
    chk("s6_word_hold", frame_word, make_word(8'h40));
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("s6_clear", 128'(underrun), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
